// File: rtl/axi_req_arbiter.sv
// Purpose : merges ICache and DCache memory requests onto the single-request
//           cache-side AXI bridge, one outstanding transaction at a time.
// Latency : *_accept in the cycle a request is seen in IDLE with the bridge
//           ready; req reaches the bridge the next cycle; *_done in the
//           task_finish cycle; earliest next accept is the cycle after done.
// Backpressure: requests stay pending (no accept) while busy or while
//           ready_to_pipline is low; clients hold their code until accept.
//
// Ports
//   clk, rstn                    clock, asynchronous active-low reset
//   i_req/i_ad/i_rword_en        ICache request code, address, LOAD_WORD size
//   i_accept/i_done              ICache request-latched / complete pulses
//   d_req/d_ad/d_wblock/d_wword/ DCache request code, address, victim line,
//   d_wword_en/d_rword_en        store word, byte strobes, LOAD_WORD size
//   d_accept/d_done              DCache request-latched / complete pulses
//   rblock_o/rword_o             bridge read data, valid with *_done
//   req/ad/wblock/wword/         registered request towards the bridge
//   wword_en/rword_en
//   ready_to_pipline             bridge idle
//   task_finish/rblock/rword     bridge completion pulse and read data
//   busy                         a transaction is outstanding
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate the winner on
// simultaneous requests; otherwise DCache has fixed priority.

module axi_req_arbiter #(
    parameter int REQ_W   = 3,
    parameter int ADDR_W  = 32,
    parameter int BLOCK_W = 256
) (
    input  logic               clk,
    input  logic               rstn,

    // ICache side
    input  logic [REQ_W-1:0]   i_req,
    input  logic [ADDR_W-1:0]  i_ad,
    input  logic [2:0]         i_rword_en,
    output logic               i_accept,
    output logic               i_done,

    // DCache side
    input  logic [REQ_W-1:0]   d_req,
    input  logic [ADDR_W-1:0]  d_ad,
    input  logic [BLOCK_W-1:0] d_wblock,
    input  logic [31:0]        d_wword,
    input  logic [3:0]         d_wword_en,
    input  logic [2:0]         d_rword_en,
    output logic               d_accept,
    output logic               d_done,

    // Read data back to both clients
    output logic [BLOCK_W-1:0] rblock_o,
    output logic [31:0]        rword_o,

    // Bridge side
    output logic [REQ_W-1:0]   req,
    output logic [ADDR_W-1:0]  ad,
    output logic [BLOCK_W-1:0] wblock,
    output logic [31:0]        wword,
    output logic [3:0]         wword_en,
    output logic [2:0]         rword_en,
    input  logic               ready_to_pipline,
    input  logic               task_finish,
    input  logic [BLOCK_W-1:0] rblock,
    input  logic [31:0]        rword,

    output logic               busy
);

    // Only the NONE encoding matters here; every other code is forwarded as-is.
    localparam logic [REQ_W-1:0] REQ_NONE = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_FIN = 2'd2
    } state_t;

    typedef enum logic {
        OWN_ICACHE = 1'b0,
        OWN_DCACHE = 1'b1
    } owner_t;

    state_t               state_q;
    state_t               state_d;
    owner_t               owner_q;
    logic [REQ_W-1:0]     req_q;
    logic [ADDR_W-1:0]    ad_q;
    logic [BLOCK_W-1:0]   wblock_q;
    logic [31:0]          wword_q;
    logic [3:0]           wword_en_q;
    logic [2:0]           rword_en_q;

    logic                 i_vld;
    logic                 d_vld;
    logic                 d_wins;
    logic                 grant_vld;
    logic                 fin_vld;

    // Winner's fields, muxed ahead of the output registers.
    logic [REQ_W-1:0]     win_req;
    logic [ADDR_W-1:0]    win_ad;
    logic [BLOCK_W-1:0]   win_wblock;
    logic [31:0]          win_wword;
    logic [3:0]           win_wword_en;
    logic [2:0]           win_rword_en;

    assign i_vld = (i_req != REQ_NONE);
    assign d_vld = (d_req != REQ_NONE);

`ifdef ARB_ROUND_ROBIN_EN
    // Owner of the most recent accept; loses the next tie. Starts at ICACHE
    // so that DCache wins the first tie after reset.
    owner_t last_owner_q;

    assign d_wins = d_vld && (!i_vld || (last_owner_q == OWN_ICACHE));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_owner_q <= OWN_ICACHE;
        end else if (grant_vld) begin
            last_owner_q <= d_wins ? OWN_DCACHE : OWN_ICACHE;
        end
    end
`else
    // Fixed priority: a steady DCache stream can starve the ICache.
    assign d_wins = d_vld;
`endif

    // A grant is only possible from IDLE with the bridge idle.
    assign grant_vld = (state_q == IDLE) && ready_to_pipline && (i_vld || d_vld);
    assign d_accept  = grant_vld && d_wins;
    assign i_accept  = grant_vld && !d_wins;

    // Completion is only honoured once the request has been issued; a stray
    // task_finish in IDLE or ISSUE is ignored.
    assign fin_vld = (state_q == WAIT_FIN) && task_finish;
    assign i_done  = fin_vld && (owner_q == OWN_ICACHE);
    assign d_done  = fin_vld && (owner_q == OWN_DCACHE);

    // Read data is not registered: clients sample it alongside *_done.
    assign rblock_o = rblock;
    assign rword_o  = rword;

    assign req      = req_q;
    assign ad       = ad_q;
    assign wblock   = wblock_q;
    assign wword    = wword_q;
    assign wword_en = wword_en_q;
    assign rword_en = rword_en_q;
    assign busy     = (state_q != IDLE);

    // ICache only issues loads, so its write payload is zero-filled.
    always_comb begin
        win_req      = i_req;
        win_ad       = i_ad;
        win_wblock   = '0;
        win_wword    = '0;
        win_wword_en = '0;
        win_rword_en = i_rword_en;
        if (d_wins) begin
            win_req      = d_req;
            win_ad       = d_ad;
            win_wblock   = d_wblock;
            win_wword    = d_wword;
            win_wword_en = d_wword_en;
            win_rword_en = d_rword_en;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (grant_vld) state_d = ISSUE;
            ISSUE:    state_d = WAIT_FIN;
            WAIT_FIN: if (task_finish) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State plus all bridge-facing registers. The payload is captured once at
    // accept and held untouched until the next accept, because the bridge
    // samples it after the one-cycle req strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            owner_q    <= OWN_DCACHE;
            req_q      <= REQ_NONE;
            ad_q       <= '0;
            wblock_q   <= '0;
            wword_q    <= '0;
            wword_en_q <= '0;
            rword_en_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        owner_q    <= d_wins ? OWN_DCACHE : OWN_ICACHE;
                        req_q      <= win_req;
                        ad_q       <= win_ad;
                        wblock_q   <= win_wblock;
                        wword_q    <= win_wword;
                        wword_en_q <= win_wword_en;
                        rword_en_q <= win_rword_en;
                    end
                end
                ISSUE: begin
                    // req is a single-cycle strobe to the bridge.
                    req_q <= REQ_NONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_req_arbiter.sv
module tb_axi_req_arbiter;

    localparam logic [2:0] R_NONE = 3'd0;
    localparam logic [2:0] R_LW   = 3'd1;
    localparam logic [2:0] R_WW   = 3'd2;
    localparam logic [2:0] R_LB   = 3'd3;
    localparam logic [2:0] R_WB   = 3'd4;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic [2:0]   i_req;
    logic [31:0]  i_ad;
    logic [2:0]   i_rword_en;
    logic         i_accept, i_done;
    logic [2:0]   d_req;
    logic [31:0]  d_ad;
    logic [255:0] d_wblock;
    logic [31:0]  d_wword;
    logic [3:0]   d_wword_en;
    logic [2:0]   d_rword_en;
    logic         d_accept, d_done;
    logic [255:0] rblock_o;
    logic [31:0]  rword_o;
    logic [2:0]   req;
    logic [31:0]  ad;
    logic [255:0] wblock;
    logic [31:0]  wword;
    logic [3:0]   wword_en;
    logic [2:0]   rword_en;
    logic         ready_to_pipline;
    logic         task_finish;
    logic [255:0] rblock;
    logic [31:0]  rword;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    axi_req_arbiter dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_ad(i_ad), .i_rword_en(i_rword_en),
        .i_accept(i_accept), .i_done(i_done),
        .d_req(d_req), .d_ad(d_ad), .d_wblock(d_wblock), .d_wword(d_wword),
        .d_wword_en(d_wword_en), .d_rword_en(d_rword_en),
        .d_accept(d_accept), .d_done(d_done),
        .rblock_o(rblock_o), .rword_o(rword_o),
        .req(req), .ad(ad), .wblock(wblock), .wword(wword),
        .wword_en(wword_en), .rword_en(rword_en),
        .ready_to_pipline(ready_to_pipline), .task_finish(task_finish),
        .rblock(rblock), .rword(rword), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Entered at the negedge of an accept cycle; runs that transaction to
    // completion with the client dropping its request after accept.
    task automatic finish_txn(input bit is_d);
        tick();
        if (is_d) d_req = R_NONE; else i_req = R_NONE;
        tick();
        task_finish = 1'b1;
        @(negedge clk);
        chk("txn_d_done", d_done, is_d);
        chk("txn_i_done", i_done, !is_d);
        tick();
        task_finish = 1'b0;
    endtask

    // Reference-model state (transaction level)
    bit           m_busy, m_own_d, m_last_d;
    int           m_age;
    logic [2:0]   m_code, m_ren;
    logic [31:0]  m_ad, m_wword;
    logic [255:0] m_wblock;
    logic [3:0]   m_wen;
    int           i_st, d_st;

    initial begin
        logic [255:0] pat;
        logic [255:0] w1;
        bit first_d;
        bit tie_d, any, acc, win_d, e_i_acc, e_d_acc, w_i_done, w_d_done;
        logic [2:0] e_req;

        rstn = 1'b0;
        i_req = R_NONE; i_ad = '0; i_rword_en = '0;
        d_req = R_NONE; d_ad = '0; d_wblock = '0; d_wword = '0;
        d_wword_en = '0; d_rword_en = '0;
        ready_to_pipline = 1'b1; task_finish = 1'b0;
        rblock = '0; rword = '0;

        // ---------------- reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", req, R_NONE);
        chk("rst_ad", ad, 0);
        chk("rst_wblock", wblock, 0);
        chk("rst_wword", wword, 0);
        chk("rst_wword_en", wword_en, 0);
        chk("rst_rword_en", rword_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_accept", {i_accept, d_accept}, 0);
        chk("rst_done", {i_done, d_done}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // ---------------- ICache LOAD_BLOCK
        i_req = R_LB; i_ad = 32'h1C000040; i_rword_en = 3'd5;
        d_wblock = {8{32'hA5A5_5A5A}}; d_wword = 32'h1111_2222; d_wword_en = 4'hF;
        @(negedge clk);
        chk("t1_i_accept", i_accept, 1);
        chk("t1_d_accept", d_accept, 0);
        chk("t1_req_c0", req, R_NONE);
        tick();
        i_req = R_NONE;
        @(negedge clk);
        chk("t1_req_c1", req, R_LB);
        chk("t1_ad_c1", ad, 32'h1C000040);
        chk("t1_rword_en", rword_en, 3'd5);
        chk("t1_wblock_zero", wblock, 0);
        chk("t1_wword_zero", wword, 0);
        chk("t1_wword_en_zero", wword_en, 0);
        chk("t1_busy", busy, 1);
        tick();
        @(negedge clk);
        chk("t1_req_c2", req, R_NONE);
        chk("t1_ad_c2", ad, 32'h1C000040);
        tick();
        pat = rnd256();
        task_finish = 1'b1; rblock = pat; rword = 32'hCAFEF00D;
        @(negedge clk);
        chk("t1_i_done", i_done, 1);
        chk("t1_d_done", d_done, 0);
        chk("t1_rblock_o", rblock_o, pat);
        chk("t1_rword_o", rword_o, 32'hCAFEF00D);
        tick();
        task_finish = 1'b0;
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_done", i_done, 0);

        // ---------------- DCache WRITE_WORD, payload held after accept
        tick();
        d_req = R_WW; d_ad = 32'h8000_1000; d_wword = 32'hDEADBEEF;
        d_wword_en = 4'b0011; d_rword_en = 3'd0;
        @(negedge clk);
        chk("t2_d_accept", d_accept, 1);
        chk("t2_i_accept", i_accept, 0);
        tick();
        d_req = R_NONE; d_wword = 32'h1234_5678; d_wword_en = 4'b1111; d_ad = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_req", req, (k == 0) ? R_WW : R_NONE);
            chk("t2_wword", wword, 32'hDEADBEEF);
            chk("t2_wword_en", wword_en, 4'b0011);
            chk("t2_ad", ad, 32'h8000_1000);
            tick();
        end
        task_finish = 1'b1;
        @(negedge clk);
        chk("t2_d_done", d_done, 1);
        chk("t2_i_done", i_done, 0);
        chk("t2_wword_fin", wword, 32'hDEADBEEF);
        tick();
        task_finish = 1'b0;

        // ---------------- simultaneous requests, tie A
        w1 = rnd256();
        i_req = R_LB; i_ad = 32'h0000_2000;
        d_req = R_WB; d_ad = 32'h0000_3000; d_wblock = w1;
        @(negedge clk);
        chk("t3_d_accept", d_accept, 1);
        chk("t3_i_accept", i_accept, 0);
        tick();
        d_req = R_NONE; d_wblock = '0;
        @(negedge clk);
        chk("t3_req_wb", req, R_WB);
        chk("t3_wblock", wblock, w1);
        chk("t3_i_pending_issue", i_accept, 0);
        tick();
        @(negedge clk);
        chk("t3_i_pending_wait", i_accept, 0);
        tick();
        task_finish = 1'b1;
        @(negedge clk);
        chk("t3_d_done", d_done, 1);
        chk("t3_i_accept_in_done", i_accept, 0);
        tick();
        task_finish = 1'b0;
        @(negedge clk);
        chk("t3_i_accept_after", i_accept, 1);
        finish_txn(1'b0);

        // ---------------- tie B: DCache wins, then re-requests in its done cycle
        i_req = R_LB; d_req = R_WB;
        @(negedge clk);
        chk("t3b_d_accept", d_accept, 1);
        chk("t3b_i_accept", i_accept, 0);
        tick();
        d_req = R_NONE;
        tick();
        task_finish = 1'b1; d_req = R_LW;
        @(negedge clk);
        chk("t3b_d_done", d_done, 1);
        chk("t3b_no_accept_in_done", {i_accept, d_accept}, 0);
        tick();
        task_finish = 1'b0;
        first_d = !RR;
        @(negedge clk);
        chk("t3b_tie_d_accept", d_accept, first_d);
        chk("t3b_tie_i_accept", i_accept, !first_d);
        finish_txn(first_d);
        @(negedge clk);
        chk("t3b_second_d_accept", d_accept, !first_d);
        chk("t3b_second_i_accept", i_accept, first_d);
        finish_txn(!first_d);

        // ---------------- bridge not ready
        ready_to_pipline = 1'b0;
        d_req = R_LW; d_ad = 32'h4000_0004; d_rword_en = 3'd2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_no_accept", d_accept, 0);
            chk("t4_req_none", req, R_NONE);
            chk("t4_busy", busy, 0);
            tick();
        end
        ready_to_pipline = 1'b1;
        @(negedge clk);
        chk("t4_accept_ready", d_accept, 1);
        finish_txn(1'b1);

        // ---------------- reset in WAIT_FIN
        d_req = R_WB; d_ad = 32'h5555_0000; d_wblock = rnd256();
        d_wword = 32'h7777_8888; d_wword_en = 4'hA; d_rword_en = 3'd3;
        @(negedge clk);
        chk("t5_d_accept", d_accept, 1);
        tick();
        d_req = R_NONE;
        tick();
        @(negedge clk);
        chk("t5_busy_wait", busy, 1);
        #2;
        rstn = 1'b0; task_finish = 1'b1;
        #1;
        chk("t5_req", req, R_NONE);
        chk("t5_ad", ad, 0);
        chk("t5_wblock", wblock, 0);
        chk("t5_wword", wword, 0);
        chk("t5_wword_en", wword_en, 0);
        chk("t5_rword_en", rword_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_no_done", {i_done, d_done}, 0);
        @(posedge clk); #1;
        rstn = 1'b1; task_finish = 1'b0;
        i_req = R_LW; i_ad = 32'h1C00_0100; i_rword_en = 3'd2;
        @(negedge clk);
        chk("t5_accept_after_rst", i_accept, 1);
        finish_txn(1'b0);

        // ---------------- stray task_finish in IDLE
        task_finish = 1'b1;
        @(negedge clk);
        chk("t6_no_done", {i_done, d_done}, 0);
        chk("t6_busy", busy, 0);
        tick();
        task_finish = 1'b0;
        @(negedge clk);
        chk("t6_busy_after", busy, 0);
        chk("t6_req_after", req, R_NONE);

        // ---------------- randomized traffic against the reference model
        rstn = 1'b0;
        i_req = R_NONE; d_req = R_NONE;
        tick();
        rstn = 1'b1;
        m_busy = 0; m_own_d = 1; m_last_d = 0; m_age = 0;
        m_code = '0; m_ren = '0; m_ad = '0; m_wword = '0; m_wblock = '0; m_wen = '0;
        i_st = 0; d_st = 0;
        for (int c = 0; c < 2000; c++) begin
            ready_to_pipline = ($urandom_range(0, 3) != 0);
            task_finish      = ($urandom_range(0, 3) == 0);
            rblock = rnd256(); rword = $urandom;
            d_wblock = rnd256(); d_wword = $urandom;
            d_wword_en = 4'($urandom); d_rword_en = 3'($urandom);

            w_i_done = m_busy && (m_age >= 2) && task_finish && !m_own_d;
            w_d_done = m_busy && (m_age >= 2) && task_finish &&  m_own_d;

            // ICache client: 0 idle, 1 requesting, 2 waiting for done
            if (i_st == 2) begin
                i_req = R_NONE;
                if (w_i_done) i_st = 0;
            end
            if (i_st == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    i_req = 3'($urandom_range(1, 4)); i_ad = $urandom;
                    i_rword_en = 3'($urandom); i_st = 1;
                end
            end else if (i_st == 1 && $urandom_range(0, 7) == 0) begin
                i_req = R_NONE; i_st = 0;
            end
            // DCache client
            if (d_st == 2) begin
                d_req = R_NONE;
                if (w_d_done) d_st = 0;
            end
            if (d_st == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 3'($urandom_range(1, 4)); d_ad = $urandom; d_st = 1;
                end
            end else if (d_st == 1 && $urandom_range(0, 7) == 0) begin
                d_req = R_NONE; d_st = 0;
            end

            tie_d   = RR ? !m_last_d : 1'b1;
            any     = (i_req != R_NONE) || (d_req != R_NONE);
            acc     = !m_busy && ready_to_pipline && any;
            win_d   = (d_req != R_NONE) && ((i_req == R_NONE) || tie_d);
            e_i_acc = acc && !win_d;
            e_d_acc = acc && win_d;
            e_req   = (m_busy && m_age == 1) ? m_code : R_NONE;

            @(negedge clk);
            chk("r_i_accept", i_accept, e_i_acc);
            chk("r_d_accept", d_accept, e_d_acc);
            chk("r_i_done", i_done, w_i_done);
            chk("r_d_done", d_done, w_d_done);
            chk("r_busy", busy, m_busy);
            chk("r_req", req, e_req);
            chk("r_rblock_o", rblock_o, rblock);
            chk("r_rword_o", rword_o, rword);
            if (m_busy) begin
                chk("r_ad", ad, m_ad);
                chk("r_wblock", wblock, m_wblock);
                chk("r_wword", wword, m_wword);
                chk("r_wword_en", wword_en, m_wen);
                chk("r_rword_en", rword_en, m_ren);
            end

            if (m_busy) begin
                if (w_i_done || w_d_done) m_busy = 0;
                else m_age++;
            end else if (acc) begin
                m_busy = 1; m_age = 1; m_own_d = win_d; m_last_d = win_d;
                if (win_d) begin
                    m_code = d_req; m_ad = d_ad; m_wblock = d_wblock;
                    m_wword = d_wword; m_wen = d_wword_en; m_ren = d_rword_en;
                    d_st = 2;
                end else begin
                    m_code = i_req; m_ad = i_ad; m_wblock = '0;
                    m_wword = '0; m_wen = '0; m_ren = i_rword_en;
                    i_st = 2;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
